// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding unit: load-use stall/bubble, branch flush, EX operand forwarding.
// Ports: ID sources/use bits, EX/MEM dst+ctl, pcsrc, clr_cnt -> stall/bubble/flush_*, fwd_a/b, event counters.
module hazard_forward_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             mem_regwrite,
    input  logic             pcsrc,
    input  logic             clr_cnt,
    output logic             stall,
    output logic             bubble,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    logic             rs_ex, rt_ex, rs_mem, rt_mem;
    logic             lu;
    logic [1:0]       sel_a, sel_b;
    logic [1:0]       fwd_a_d, fwd_a_q;
    logic [1:0]       fwd_b_d, fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    // $0 is hardwired, so it never produces a hazard or a forward.
    function automatic logic hit(
        input logic             use_i,
        input logic             wr_i,
        input logic [REG_W-1:0] src_i,
        input logic [REG_W-1:0] dst_i
    );
        return use_i && wr_i && (src_i == dst_i) && (src_i != '0);
    endfunction

    assign rs_ex  = hit(id_use_rs, ex_regwrite, id_rs, ex_dst);
    assign rt_ex  = hit(id_use_rt, ex_regwrite, id_rt, ex_dst);
    assign rs_mem = hit(id_use_rs, mem_regwrite, id_rs, mem_dst);
    assign rt_mem = hit(id_use_rt, mem_regwrite, id_rt, mem_dst);

    assign lu = ex_memread && (rs_ex || rt_ex);

    // Redirect wins over load-use; all hazard controls are quiet in reset.
    assign stall       = rst && lu && !pcsrc;
    assign bubble      = stall;
    assign flush_ifid  = rst && pcsrc;
    assign flush_idex  = rst && pcsrc;
    assign flush_exmem = rst && pcsrc;

    // A non-load in EX reaches MEM next cycle; the younger producer wins.
    always_comb begin
        sel_a = FWD_RF;
        if (rs_ex && !ex_memread) sel_a = FWD_MEM;
        else if (rs_mem)          sel_a = FWD_WB;
        sel_b = FWD_RF;
        if (rt_ex && !ex_memread) sel_b = FWD_MEM;
        else if (rt_mem)          sel_b = FWD_WB;
    end

    // A bubble or flushed slot enters EX and must not forward.
    always_comb begin
        fwd_a_d = sel_a;
        fwd_b_d = sel_b;
        if (pcsrc || lu) begin
            fwd_a_d = FWD_RF;
            fwd_b_d = FWD_RF;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
            if (pcsrc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed vector bench for hazard_forward_unit.
// Table-driven combinational/forward checks plus reset, mid-op reset and saturation sequences.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_dst, mem_dst;
    logic        id_use_rs, id_use_rt, ex_regwrite, ex_memread, mem_regwrite;
    logic        pcsrc, clr_cnt;
    logic        stall, bubble, flush_ifid, flush_idex, flush_exmem;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_sc   = 0;
    int exp_fc   = 0;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_dst(ex_dst), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_dst(mem_dst), .mem_regwrite(mem_regwrite),
        .pcsrc(pcsrc), .clr_cnt(clr_cnt),
        .stall(stall), .bubble(bubble),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] exd;
        logic       exw, exm;
        logic [4:0] memd;
        logic       memw, pc;
        logic       st;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t v[12];

    function automatic vec_t mk(input string n,
        input int rs, input int rt, input int urs, input int urt,
        input int exd, input int exw, input int exm,
        input int memd, input int memw, input int pc,
        input int st, input int fa, input int fb);
        vec_t r;
        r.name = n;
        r.rs = 5'(rs);   r.rt = 5'(rt);
        r.urs = 1'(urs); r.urt = 1'(urt);
        r.exd = 5'(exd); r.exw = 1'(exw); r.exm = 1'(exm);
        r.memd = 5'(memd); r.memw = 1'(memw); r.pc = 1'(pc);
        r.st = 1'(st); r.fa = 2'(fa); r.fb = 2'(fb);
        return r;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        id_rs = x.rs; id_rt = x.rt; id_use_rs = x.urs; id_use_rt = x.urt;
        ex_dst = x.exd; ex_regwrite = x.exw; ex_memread = x.exm;
        mem_dst = x.memd; mem_regwrite = x.memw; pcsrc = x.pc;
    endtask

    task automatic idle();
        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        v[0]  = mk("alu_b2b",   8, 0, 1, 0, 8, 1, 0, 0, 0, 0, 0, 1, 0);
        v[1]  = mk("load_use",  0, 9, 0, 1, 9, 1, 1, 0, 0, 0, 1, 0, 0);
        v[2]  = mk("after_lu",  0, 9, 0, 1, 0, 0, 0, 9, 1, 0, 0, 0, 2);
        v[3]  = mk("prio_ex",   5, 0, 1, 0, 5, 1, 0, 5, 1, 0, 0, 1, 0);
        v[4]  = mk("reg0",      0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        v[5]  = mk("flush_lu",  0, 9, 0, 1, 9, 1, 1, 0, 0, 1, 0, 0, 0);
        v[6]  = mk("flush_alu", 8, 0, 1, 0, 8, 1, 0, 0, 0, 1, 0, 0, 0);
        v[7]  = mk("no_use",    8, 8, 0, 0, 8, 1, 0, 8, 1, 0, 0, 0, 0);
        v[8]  = mk("no_wr",     8, 8, 1, 1, 8, 0, 0, 8, 0, 0, 0, 0, 0);
        v[9]  = mk("both_ops",  3, 4, 1, 1, 3, 1, 0, 4, 1, 0, 0, 1, 2);
        v[10] = mk("ld_mem_hit",6, 0, 1, 0, 7, 1, 1, 6, 1, 0, 0, 2, 0);
        v[11] = mk("ld_no_wr",  7, 0, 1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0);

        // Reset held with a flushing load-use: everything quiet.
        rst = 1'b0; clr_cnt = 1'b0;
        drive(v[5]);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall",  stall, 0);
        chk("rst_bubble", bubble, 0);
        chk("rst_flush",  {flush_ifid, flush_idex, flush_exmem}, 0);
        chk("rst_fwd",    {fwd_a, fwd_b}, 0);
        chk("rst_scnt",   stall_cnt, 0);
        chk("rst_fcnt",   flush_cnt, 0);

        @(negedge clk);
        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rel_scnt", stall_cnt, 0);
        chk("rel_fcnt", flush_cnt, 0);

        foreach (v[i]) begin
            @(negedge clk);
            drive(v[i]);
            #1;
            chk({v[i].name, "_stall"},  stall, v[i].st);
            chk({v[i].name, "_bubble"}, bubble, v[i].st);
            chk({v[i].name, "_flush"},
                {flush_ifid, flush_idex, flush_exmem}, {3{v[i].pc}});
            if (v[i].st) exp_sc++;
            if (v[i].pc) exp_fc++;
            @(posedge clk);
            #1;
            chk({v[i].name, "_fwd_a"}, fwd_a, v[i].fa);
            chk({v[i].name, "_fwd_b"}, fwd_b, v[i].fb);
            chk({v[i].name, "_scnt"},  stall_cnt, exp_sc);
            chk({v[i].name, "_fcnt"},  flush_cnt, exp_fc);
        end

        // Mid-operation async reset clears registers without waiting for an edge.
        @(negedge clk);
        drive(v[9]);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_fwd",  {fwd_a, fwd_b}, 0);
        chk("midrst_fcnt", flush_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(v[9]);
        @(posedge clk);
        #1;
        chk("postrst_fwd", {fwd_a, fwd_b}, {2'd1, 2'd2});

        // Saturation: 2^16+3 stall cycles.
        @(negedge clk);
        drive(v[1]);
        repeat (65539) @(posedge clk);
        #1;
        chk("sat_scnt", stall_cnt, 16'hFFFF);
        chk("sat_fcnt", flush_cnt, 0);
        @(negedge clk);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_scnt", stall_cnt, 0);
        @(negedge clk);
        clr_cnt = 1'b0;
        drive(v[6]);
        @(posedge clk);
        #1;
        chk("flush_after_clr", flush_cnt, 1);
        chk("stall_after_clr", stall_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
